// File: rtl/m68k_bus_responder.sv
// 68000-style bus slave: registers the async AS/UDS/LDS/RW bus, decodes a window and serves a 16-bit RAM.
// Optional macro M68K_RESP_BERR_EN: selected accesses at idx >= DEPTH end with BERR instead of DTACK.
module m68k_bus_responder #(
  parameter logic [23:0] BASE        = 24'h000000,
  parameter int          ADDR_BITS   = 12,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK,
  output logic        BERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef M68K_RESP_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_IGNORE, S_WAIT, S_ACK, S_BERR} state_t;

  state_t              state, state_d;
  logic [23:1]         a_q;
  logic                as_q, uds_q, lds_q, rw_q;
  logic [15:0]         d_q;
  logic [ADDR_BITS:1]  addr_l;
  logic                rw_l, uds_l, lds_l;
  logic [3:0]          cnt, cnt_d;
  logic                dtack_r, dtack_d;
  logic                berr_r, berr_d;
  logic                oe_r, oe_d;
  logic [15:0]         dout_r, dout_d;
  logic                latch, we_hi, we_lo;
  logic                sel, in_range;
  logic [IW-1:0]       mem_idx;
  logic [15:0]         mem [DEPTH];

  assign sel     = (a_q[23:ADDR_BITS+1] == BASE[23:ADDR_BITS+1]);
  assign mem_idx = addr_l[IW:1];

  if (DEPTH >= (1 << ADDR_BITS)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (addr_l < ADDR_BITS'(DEPTH));
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dtack_d = dtack_r;
    berr_d  = berr_r;
    oe_d    = oe_r;
    dout_d  = dout_r;
    latch   = 1'b0;
    we_hi   = 1'b0;
    we_lo   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!as_q && (!uds_q || !lds_q)) begin
          latch = 1'b1;
          if (sel) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_IGNORE;
          end
        end
      end
      S_IGNORE: if (as_q) state_d = S_IDLE;
      S_WAIT: begin
        if (as_q) begin
          state_d = S_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else if (BERR_EN && !in_range) begin
          berr_d  = 1'b0;
          state_d = S_BERR;
        end else begin
          dtack_d = 1'b0;
          state_d = S_ACK;
          if (rw_l) begin
            oe_d   = 1'b1;
            dout_d = in_range ? mem[mem_idx] : 16'hFFFF;
          end else begin
            // out-of-range writes are silently dropped when BERR is not built in
            we_hi = in_range && !uds_l;
            we_lo = in_range && !lds_l;
          end
        end
      end
      S_ACK: begin
        if (as_q) begin
          dtack_d = 1'b1;
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_BERR: begin
        if (as_q) begin
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    a_q   <= A;
    as_q  <= AS;
    uds_q <= UDS;
    lds_q <= LDS;
    rw_q  <= RW;
    d_q   <= D_IN;
    if (!RESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      dtack_r <= 1'b1;
      berr_r  <= 1'b1;
      oe_r    <= 1'b0;
      dout_r  <= 16'h0000;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      dtack_r <= dtack_d;
      berr_r  <= berr_d;
      oe_r    <= oe_d;
      dout_r  <= dout_d;
      if (latch) begin
        addr_l <= a_q[ADDR_BITS:1];
        rw_l   <= rw_q;
        uds_l  <= uds_q;
        lds_l  <= lds_q;
      end
    end
  end

  // RAM is not cleared by reset; a reset edge suppresses any pending write
  always_ff @(posedge CLK) begin
    if (RESET && we_hi) mem[mem_idx][15:8] <= d_q[15:8];
    if (RESET && we_lo) mem[mem_idx][7:0]  <= d_q[7:0];
  end

  assign DTACK = dtack_r;
  assign BERR  = berr_r;
  assign D_OE  = oe_r;
  assign D_OUT = dout_r;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Randomized bus-cycle bench for m68k_bus_responder with a transaction-level reference model.
module tb_m68k_bus_responder;
  localparam int WS    = 1;
  localparam int DEPTH = 1024;

`ifdef M68K_RESP_BERR_EN
  localparam bit BERR_BUILD = 1'b1;
`else
  localparam bit BERR_BUILD = 1'b0;
`endif

  logic        CLK, RESET, AS, UDS, LDS, RW, D_OE, DTACK, BERR;
  logic [23:1] A;
  logic [15:0] D_IN, D_OUT;

  m68k_bus_responder #(.BASE(24'h000000), .ADDR_BITS(12), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .DTACK(DTACK), .BERR(BERR));

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic exp_dtack = 1, exp_berr = 1, exp_oe = 0;
  logic [15:0] exp_dout = 16'h0;
  logic [15:0] mem_m [0:1023];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  // cycle-by-cycle comparison against the model's expected bus outputs
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("dtack", 32'(DTACK), 32'(exp_dtack));
      chk("berr", 32'(BERR), 32'(exp_berr));
      chk("d_oe", 32'(D_OE), 32'(exp_oe));
      if (exp_oe) chk("d_out", 32'(D_OUT), 32'(exp_dout));
    end
  end

  // One full bus cycle. The acknowledge edge is E0+2+WS; release is one edge after AS is seen high.
  task automatic bus_cycle(input logic [23:0] baddr, input logic rw, input logic uds, input logic lds,
                           input logic [15:0] wd, input int hold, input bit rmw,
                           output int lat, output bit berr_seen, output logic [15:0] rd);
    bit sel, inr;
    int widx;
    sel = (baddr[23:13] == 11'h0);
    widx = int'(baddr[12:1]);
    inr = widx < DEPTH;
    lat = -1; berr_seen = 0; rd = 16'hxxxx;
    A = baddr[23:1]; RW = rw; UDS = uds; LDS = lds; D_IN = wd; AS = 1'b0;
    @(posedge CLK); #1;
    for (int n = 1; n <= 2 + WS + hold; n++) begin
      @(posedge CLK); #1;
      if (n == 2 + WS && sel) begin
        if (!inr && BERR_BUILD) exp_berr = 1'b0;
        else begin
          exp_dtack = 1'b0;
          if (rw) begin
            exp_oe = 1'b1;
            exp_dout = inr ? mem_m[widx] : 16'hFFFF;
          end else if (inr) begin
            if (!uds) mem_m[widx][15:8] = wd[15:8];
            if (!lds) mem_m[widx][7:0] = wd[7:0];
          end
        end
        if (rmw) begin
          RW = 1'b0; UDS = 1'b0; LDS = 1'b0; D_IN = ~wd;
        end
      end
      if (lat < 0 && (!DTACK || !BERR)) begin
        lat = n;
        berr_seen = !BERR;
      end
      if (D_OE) rd = D_OUT;
    end
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    exp_dtack = 1'b1; exp_berr = 1'b1; exp_oe = 1'b0;
  endtask

  task automatic wr(input logic [23:0] ba, input logic [15:0] wd, input logic uds, input logic lds);
    int l; bit b; logic [15:0] r;
    bus_cycle(ba, 1'b0, uds, lds, wd, 0, 0, l, b, r);
  endtask

  task automatic rd_word(input logic [23:0] ba, output logic [15:0] r, output int l);
    bit b;
    bus_cycle(ba, 1'b1, 1'b0, 1'b0, 16'h0, 1, 0, l, b, r);
  endtask

  int pool [8] = '{8, 16, 24, 976, 1023, 100, 513, 7};

  initial begin
    int l; bit b; logic [15:0] r; bit saw;
    CLK = 0; RESET = 0; AS = 1; UDS = 1; LDS = 1; RW = 1; A = '0; D_IN = '0;
    @(posedge CLK); #1; chk_en = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dtack", 32'(DTACK), 32'd1);
    chk("rst_berr", 32'(BERR), 32'd1);
    chk("rst_oe", 32'(D_OE), 32'd0);
    chk("rst_dout", 32'(D_OUT), 32'd0);
    RESET = 1;
    @(posedge CLK); #1;

    // word write/read with latency pin
    bus_cycle(24'h000010, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, 0, l, b, r);
    chk("wr_latency", 32'(l), 32'd3);
    rd_word(24'h000010, r, l);
    chk("rd_latency", 32'(l), 32'd3);
    chk("rd_beef", 32'(r), 32'hBEEF);
    chk("rel_dtack", 32'(DTACK), 32'd1);
    chk("rel_oe", 32'(D_OE), 32'd0);

    // byte lanes
    wr(24'h000020, 16'h1234, 1'b0, 1'b0);
    wr(24'h000020, 16'hAA00, 1'b0, 1'b1);
    rd_word(24'h000020, r, l);
    chk("upper_lane", 32'(r), 32'hAA34);
    wr(24'h000020, 16'h0055, 1'b1, 1'b0);
    rd_word(24'h000020, r, l);
    chk("lower_lane", 32'(r), 32'hAA55);

    // abort: AS seen high at E0+1, before the acknowledge edge
    wr(24'h000030, 16'h5A5A, 1'b0, 1'b0);
    A = 23'h18; RW = 0; UDS = 0; LDS = 0; D_IN = 16'h0F0F; AS = 0;
    @(posedge CLK); #1;
    AS = 1; UDS = 1; LDS = 1; RW = 1;
    saw = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (!DTACK) saw = 1;
    end
    chk("abort_no_dtack", 32'(saw), 32'd0);
    rd_word(24'h000030, r, l);
    chk("abort_ram", 32'(r), 32'h5A5A);

    // outside the window
    bus_cycle(24'h800000, 1'b1, 1'b0, 1'b0, 16'h0, 2, 0, l, b, r);
    chk("outside_no_ack", 32'(l), 32'hFFFFFFFF);
    rd_word(24'h000010, r, l);
    chk("after_outside", 32'(r), 32'hBEEF);

    // out-of-range index 2000 (DEPTH=1024), and no aliasing onto index 976
    wr(24'h0007A0, 16'h7777, 1'b0, 1'b0);
    bus_cycle(24'h000FA0, 1'b1, 1'b0, 1'b0, 16'h0, 1, 0, l, b, r);
    chk("oor_latency", 32'(l), 32'd3);
    chk("oor_berr_path", 32'(b), 32'(BERR_BUILD));
`ifndef M68K_RESP_BERR_EN
    chk("oor_ffff", 32'(r), 32'hFFFF);
`endif
    wr(24'h000FA0, 16'h1111, 1'b0, 1'b0);
    rd_word(24'h0007A0, r, l);
    chk("oor_no_alias", 32'(r), 32'h7777);

    // read-modify-write with AS held: second half is never acknowledged
    bus_cycle(24'h000010, 1'b1, 1'b0, 1'b0, 16'h1357, 3, 1, l, b, r);
    chk("rmw_rd", 32'(r), 32'hBEEF);
    rd_word(24'h000010, r, l);
    chk("rmw_no_write", 32'(r), 32'hBEEF);

    // AS low with both strobes high starts nothing
    A = 23'h8; AS = 0; saw = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (!DTACK) saw = 1;
    end
    AS = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("no_strobe", 32'(saw), 32'd0);

    // reset while in WAIT
    A = 23'h8; RW = 0; UDS = 0; LDS = 0; D_IN = 16'h0000; AS = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 0; AS = 1; UDS = 1; LDS = 1; RW = 1;
    @(posedge CLK); #1;
    chk("rstw_dtack", 32'(DTACK), 32'd1);
    chk("rstw_berr", 32'(BERR), 32'd1);
    chk("rstw_oe", 32'(D_OE), 32'd0);
    RESET = 1;
    @(posedge CLK); #1;
    rd_word(24'h000010, r, l);
    chk("rstw_ram", 32'(r), 32'hBEEF);

    // randomized traffic
    foreach (pool[i]) wr({11'h0, 12'(pool[i]), 1'b0}, 16'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      int kind, s, hold;
      logic [23:0] ba;
      logic rw, u, lo;
      kind = $urandom_range(0, 9);
      s = $urandom_range(0, 2);
      u = (s == 2); lo = (s == 1);
      rw = 1'($urandom);
      hold = $urandom_range(0, 3);
      if (kind < 6) ba = {11'h0, 12'(pool[$urandom_range(0, 7)]), 1'b0};
      else if (kind == 6) ba = {11'h0, 12'($urandom_range(1024, 4095)), 1'b0};
      else if (kind == 7) ba = {11'($urandom_range(1, 2047)), 12'($urandom), 1'b0};
      else ba = {11'h0, 12'(pool[$urandom_range(0, 7)]), 1'b0};
      bus_cycle(ba, rw, u, lo, 16'($urandom), hold, kind >= 8, l, b, r);
      if (ba[23:13] == 11'h0) chk("rand_latency", 32'(l), 32'(2 + WS));
      else chk("rand_outside", 32'(l), 32'hFFFFFFFF);
      if (rw && ba[23:13] == 11'h0 && ba[12:1] < 12'(DEPTH))
        chk("rand_rd", 32'(r), 32'(mem_m[int'(ba[12:1])]));
    end
    foreach (pool[i]) begin
      rd_word({11'h0, 12'(pool[i]), 1'b0}, r, l);
      chk("final_rd", 32'(r), 32'(mem_m[pool[i]]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Synchronous 68000-style bus slave: the target end of the asynchronous AS/UDS/LDS/RW/DTACK bus driven by the V68k core.
- Decodes an address window and services word/byte reads and writes from an internal 16-bit RAM.
- Closes every cycle with DTACK, or with BERR when the optional range check is compiled in.
- Sits on the system bus beside the CPU; used as program/data RAM and as the bench target for CPU bus-cycle verification.

Parameters:
- BASE, 24'h000000, byte base address of window; bits [ADDR_BITS:0] ignored.
- ADDR_BITS, 12, window spans 2^ADDR_BITS words; RAM index = A[ADDR_BITS:1].
- DEPTH, 4096, implemented words, 1..2^ADDR_BITS.
- WAIT_STATES, 1, extra cycles before DTACK, 0..15.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- A  in  23  address bus A[23:1].
- AS  in  1  address strobe, active low.
- UDS  in  1  upper data strobe (D[15:8]), active low.
- LDS  in  1  lower data strobe (D[7:0]), active low.
- RW  in  1  1 = read, 0 = write.
- D_IN  in  16  data from CPU.
- D_OUT  out  16  read data to CPU.
- D_OE  out  1  high = drive D_OUT onto D.
- DTACK  out  1  data acknowledge, active low.
- BERR  out  1  bus error, active low.

Behaviour:
- Input registering:
  - A, AS, UDS, LDS, RW and D_IN are registered once (_q copies).
  - All decisions use the _q copies.
  - Edge E0 is the first edge that captures AS=0.
- Reset (RESET=0 at an edge):
  - State returns to IDLE; DTACK=1, BERR=1, D_OE=0, D_OUT=0, wait counter 0.
  - RAM contents are not cleared.
  - Reset mid-cycle abandons the cycle with no write.
- IDLE:
  - If as_q=0 and (uds_q=0 or lds_q=0): latch addr/rw/strobes.
    - Selected (A_q[23:ADDR_BITS+1]==BASE[23:ADDR_BITS+1]): go to WAIT, cnt=WAIT_STATES.
    - Not selected: go to IGNORE.
  - AS=0 with both strobes high: remain in IDLE.
- IGNORE: no outputs driven; go to IDLE when as_q=1.
- WAIT:
  - If as_q=1: abort to IDLE; no write, no DTACK.
  - Else if cnt≠0: cnt-=1.
  - Else (cnt==0): perform the access and go to ACK, setting DTACK<=0 on the same edge.
    - Read: D_OUT<=mem[idx], D_OE<=1 on the same edge.
    - Write: mem[idx][15:8]<=d_q[15:8] if UDS latched low; mem[idx][7:0]<=d_q[7:0] if LDS latched low; D_OE stays 0.
- Latency: DTACK falls at edge E0+2+WAIT_STATES.
- ACK:
  - Hold DTACK=0, and D_OUT/D_OE for reads, while as_q=0.
  - On as_q=1: DTACK<=1, D_OE<=0, go to IDLE.
  - A new cycle starts only after AS has been seen high. A read-modify-write with AS held across both halves is acknowledged once; the second half waits for AS to negate.
- Strobe changes after latching are ignored until the cycle ends.
- DTACK and BERR are never low together; D_OE never high during a write.

Optional Feature:
- Macro: M68K_RESP_BERR_EN.
- Defined:
  - Selected access with idx>=DEPTH takes the BERR path: at the edge DTACK would fall, BERR<=0 instead, no RAM access, D_OE stays 0.
  - BERR is held until as_q=1, then BERR<=1 and state returns to IDLE.
- Undefined:
  - BERR is tied to 1.
  - Out-of-range reads return 16'hFFFF with normal DTACK.
  - Out-of-range writes are dropped with normal DTACK.
- With DEPTH=2^ADDR_BITS both builds behave identically.

Test Plan:
- Reset then word write/read: write 16'hBEEF to byte addr 0x000010 (UDS=LDS=0), then read the same address -> DTACK low at E0+3 (WAIT_STATES=1), D_OUT=16'hBEEF, D_OE=1; both DTACK and D_OE clear one edge after AS is seen high.
- Byte lanes: preload 16'h1234; write 16'hAAxx with only UDS=0 -> reads 16'hAA34; then write 16'hxx55 with only LDS=0 -> reads 16'hAA55.
- Abort: AS deasserted at E0+1 during a write of 16'h0F0F with WAIT_STATES=3 -> DTACK never falls; RAM word unchanged.
- Outside window: BASE=24'h000000, address 0x800000 -> DTACK and BERR stay high, D_OE=0; responder returns to IDLE after AS negates.
- With M68K_RESP_BERR_EN, DEPTH=1024: read word index 2000 -> BERR low at E0+3, DTACK high; without the macro -> DTACK low, D_OUT=16'hFFFF.
- Back-to-back cycles with AS held low after ACK, plus RESET=0 asserted while in WAIT -> no second acknowledge; DTACK=1, BERR=1, D_OE=0 at the next edge; RAM contents preserved.
